// File: rtl/adc_trig_pkg.sv
// Shared definitions for the ADC trigger unit: source bit positions in the
// hit/enable/source vectors and the channel detector state encoding.
package adc_trig_pkg;

  localparam int c_DATA_W   = 16;

  localparam int c_SRC_EXT  = 0;
  localparam int c_SRC_SW   = 1;
  localparam int c_SRC_TIME = 2;
  localparam int c_SRC_CH1  = 3;
  localparam int c_SRC_CH2  = 4;
  localparam int c_SRC_CH3  = 5;
  localparam int c_SRC_CH4  = 6;

  localparam int c_NB_FIXED_SRC = 3;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    ARMED      = 2'd1,
    DISARMED   = 2'd2
  } det_state_t;

endpackage

// File: rtl/adc_trig_thres_det.sv
// Threshold crossing detector with hysteresis for one ADC channel.
// The hit output is combinational and is registered by the parent.
module adc_trig_thres_det
  import adc_trig_pkg::*;
#(
  parameter int g_DATA_W = c_DATA_W
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       valid,
  input  logic signed [g_DATA_W-1:0] sample,
  input  logic signed [g_DATA_W-1:0] thres,
  input  logic        [g_DATA_W-1:0] hyst,
  input  logic                       pol,
  output logic                       hit
);

  localparam int c_EXT_W = g_DATA_W + 2;

  det_state_t state_reg, state_next;

  logic signed [c_EXT_W-1:0] sample_ext;
  logic signed [c_EXT_W-1:0] thres_ext;
  logic signed [c_EXT_W-1:0] hyst_ext;
  logic signed [c_EXT_W-1:0] rearm_lvl;
  logic                      on_armed_side;
  logic                      past_rearm;

  // Two guard bits keep thres +/- hyst exact over the full input range.
  always_comb begin
    sample_ext = {{2{sample[g_DATA_W-1]}}, sample};
    thres_ext  = {{2{thres[g_DATA_W-1]}}, thres};
    hyst_ext   = {2'b00, hyst};
    rearm_lvl  = pol ? (thres_ext + hyst_ext) : (thres_ext - hyst_ext);
    on_armed_side = pol ? (sample_ext > thres_ext) : (sample_ext < thres_ext);
    past_rearm    = pol ? (sample_ext > rearm_lvl) : (sample_ext < rearm_lvl);
  end

  always_comb begin
    state_next = state_reg;
    hit        = 1'b0;
    if (valid) begin
      case (state_reg)
        WAIT_FIRST: state_next = on_armed_side ? ARMED : DISARMED;
        ARMED: begin
          if (!on_armed_side) begin
            hit        = 1'b1;
            state_next = DISARMED;
          end
        end
        DISARMED: begin
          if (past_rearm) state_next = ARMED;
        end
        default: state_next = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) state_reg <= WAIT_FIRST;
    else      state_reg <= state_next;
  end

endmodule

// File: rtl/adc_trig_unit.sv
// Trigger unit: channel threshold, delayed external, software and time
// sources feed a two-stage pipeline producing one qualified trigger pulse.
module adc_trig_unit
  import adc_trig_pkg::*;
#(
  parameter int g_NB_CHAN = 4,
  parameter int g_DATA_W  = c_DATA_W,
  parameter int g_DLY_W   = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [g_NB_CHAN*g_DATA_W-1:0]   adc_data_i,
  input  logic                            adc_valid_i,
  input  logic [g_NB_CHAN*g_DATA_W-1:0]   ch_thres_val_i,
  input  logic [g_NB_CHAN*g_DATA_W-1:0]   ch_thres_hyst_i,
  input  logic [g_NB_CHAN-1:0]            ch_pol_i,
  input  logic [c_NB_FIXED_SRC+g_NB_CHAN-1:0] trig_en_i,
  input  logic                            ext_trig_i,
  input  logic                            ext_pol_i,
  input  logic [g_DLY_W-1:0]              ext_dly_i,
  input  logic                            sw_trig_i,
  input  logic                            time_trig_i,
  input  logic                            arm_i,
  output logic                            trig_o,
  output logic [c_NB_FIXED_SRC+g_NB_CHAN-1:0] trig_src_o,
  output logic [31:0]                     trig_cnt_o
);

  localparam int c_NB_SRC = c_NB_FIXED_SRC + g_NB_CHAN;

  logic [g_NB_CHAN-1:0] ch_hit;
  logic [c_NB_SRC-1:0]  hit_next, hit_reg;
  logic [c_NB_SRC-1:0]  src_hit;
  logic                 trig_fire;
  logic                 trig_reg;
  logic [c_NB_SRC-1:0]  src_reg;
  logic [31:0]          cnt_reg;

  logic                 ext_q_reg;
  logic                 ext_edge;
  logic                 ext_hit;
  logic [g_DLY_W-1:0]   dly_cnt_reg, dly_cnt_next;

  generate
    for (genvar gi = 0; gi < g_NB_CHAN; gi++) begin : g_det
      adc_trig_thres_det #(
        .g_DATA_W (g_DATA_W)
      ) u_det (
        .clk    (clk_i),
        .srst   (rst_i),
        .valid  (adc_valid_i),
        .sample (adc_data_i[gi*g_DATA_W +: g_DATA_W]),
        .thres  (ch_thres_val_i[gi*g_DATA_W +: g_DATA_W]),
        .hyst   (ch_thres_hyst_i[gi*g_DATA_W +: g_DATA_W]),
        .pol    (ch_pol_i[gi]),
        .hit    (ch_hit[gi])
      );
    end
  endgenerate

  // A non-zero count means a delayed external trigger is pending; new edges
  // are ignored until it expires or the unit is disarmed.
  always_comb begin
    ext_edge     = ext_pol_i ? (ext_q_reg & ~ext_trig_i) : (~ext_q_reg & ext_trig_i);
    dly_cnt_next = dly_cnt_reg;
    ext_hit      = 1'b0;
    if (!arm_i) begin
      dly_cnt_next = '0;
    end else if (dly_cnt_reg != '0) begin
      dly_cnt_next = dly_cnt_reg - g_DLY_W'(1);
      ext_hit      = (dly_cnt_reg == g_DLY_W'(1));
    end else if (ext_edge) begin
      if (ext_dly_i == '0) ext_hit = 1'b1;
      else                 dly_cnt_next = ext_dly_i;
    end
  end

  always_comb begin
    hit_next                              = '0;
    hit_next[c_SRC_EXT]                   = ext_hit;
    hit_next[c_SRC_SW]                    = sw_trig_i;
    hit_next[c_SRC_TIME]                  = time_trig_i;
    hit_next[c_NB_SRC-1:c_SRC_CH1]        = ch_hit;
  end

  always_comb begin
    src_hit   = hit_reg & trig_en_i;
    trig_fire = arm_i & (|src_hit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ext_q_reg   <= ext_trig_i;
      dly_cnt_reg <= '0;
      hit_reg     <= '0;
      trig_reg    <= 1'b0;
      src_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      ext_q_reg   <= ext_trig_i;
      dly_cnt_reg <= dly_cnt_next;
      hit_reg     <= hit_next;
      trig_reg    <= trig_fire;
      if (trig_fire) begin
        src_reg <= src_hit;
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign trig_o     = trig_reg;
  assign trig_src_o = src_reg;
  assign trig_cnt_o = cnt_reg;

endmodule

// File: tb/tb_adc_trig_unit.sv
// Scoreboard bench for adc_trig_unit: every expected trigger (cycle, source
// vector, count) is queued at stimulus time and matched by a trigger monitor.
module tb_adc_trig_unit;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int NS  = 3 + NCH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [NCH*DW-1:0] thres_val = '0;
  logic [NCH*DW-1:0] thres_hyst = '0;
  logic [NCH-1:0]    ch_pol = '0;
  logic [NS-1:0]     trig_en = '0;
  logic              ext_trig = 1'b0;
  logic              ext_pol = 1'b0;
  logic [31:0]       ext_dly = '0;
  logic              sw_trig = 1'b0;
  logic              time_trig = 1'b0;
  logic              arm = 1'b0;
  logic              trig_o;
  logic [NS-1:0]     trig_src_o;
  logic [31:0]       trig_cnt_o;

  adc_trig_unit #(.g_NB_CHAN(NCH), .g_DATA_W(DW), .g_DLY_W(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .adc_data_i      (adc_data),
    .adc_valid_i     (adc_valid),
    .ch_thres_val_i  (thres_val),
    .ch_thres_hyst_i (thres_hyst),
    .ch_pol_i        (ch_pol),
    .trig_en_i       (trig_en),
    .ext_trig_i      (ext_trig),
    .ext_pol_i       (ext_pol),
    .ext_dly_i       (ext_dly),
    .sw_trig_i       (sw_trig),
    .time_trig_i     (time_trig),
    .arm_i           (arm),
    .trig_o          (trig_o),
    .trig_src_o      (trig_src_o),
    .trig_cnt_o      (trig_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [NS-1:0] src;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_trig(input int lat, input logic [NS-1:0] src);
    exp_t e;
    exp_cnt  = exp_cnt + 1;
    e.cyc    = cyc + lat;
    e.src    = src;
    e.cnt    = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic set_ch(input int k, input int v);
    adc_data[k*DW +: DW] = DW'(v);
  endtask

  // Trigger monitor: matches each trig_o pulse against the scoreboard head and
  // flags any expected trigger whose cycle has passed without a pulse.
  always @(negedge clk) begin
    if (!rst && trig_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_trig cyc=%0d src=%h cnt=%0d", cyc, trig_src_o, trig_cnt_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (cyc !== mon_e.cyc || trig_src_o !== mon_e.src || trig_cnt_o !== mon_e.cnt) begin
          errors++;
          $display("FAIL trig_match got cyc=%0d src=%h cnt=%0d want cyc=%0d src=%h cnt=%0d",
                   cyc, trig_src_o, trig_cnt_o, mon_e.cyc, mon_e.src, mon_e.cnt);
        end
      end
    end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      checks++;
      errors++;
      mon_e = sb_q.pop_front();
      $display("FAIL missing_trig got none at cyc=%0d want src=%h cnt=%0d", cyc, mon_e.src, mon_e.cnt);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (trig_o !== 1'b0 || trig_src_o !== '0 || trig_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got trig=%b src=%h cnt=%0d want 0 00 0", trig_o, trig_src_o, trig_cnt_o);
    end
    rst = 1'b0;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_sw();
    arm = 1'b1;
    trig_en = 7'h02;
    sw_trig = 1'b1; push_trig(2, 7'h02); tick(); sw_trig = 1'b0;
    repeat (4) tick();
    // time trigger is masked by the enable vector
    time_trig = 1'b1; tick(); time_trig = 1'b0;
    repeat (4) tick();
    arm = 1'b0;
    sw_trig = 1'b1; tick(); sw_trig = 1'b0;
    repeat (4) tick();
    checks++;
    if (trig_src_o !== 7'h02 || trig_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL sw_disarmed_hold got src=%h cnt=%0d want src=02 cnt=1", trig_src_o, trig_cnt_o);
    end
    arm = 1'b1;
    tick();
  endtask

  task automatic test_ch1_ramp();
    trig_en = 7'h08;
    adc_valid = 1'b1;
    for (int v = 0; v <= 800; v += 8) begin
      set_ch(0, v);
      if (v == 768) push_trig(2, 7'h08);
      tick();
    end
    for (int v = 792; v >= 504; v -= 8) begin set_ch(0, v); tick(); end
    for (int v = 512; v <= 800; v += 8) begin
      set_ch(0, v);
      if (v == 768) push_trig(2, 7'h08);
      tick();
    end
    for (int v = 792; v >= 504; v -= 8) begin set_ch(0, v); tick(); end
    for (int i = 0; i < 8; i++) begin
      set_ch(0, (i % 2 == 0) ? 760 : 776);
      if (i == 1) push_trig(2, 7'h08);
      tick();
    end
    adc_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL ch1_pending got %0d queued want 0", sb_q.size());
    end
  endtask

  task automatic test_ch_falling();
    trig_en = 7'h10;
    adc_valid = 1'b1;
    set_ch(1, -50);  tick();
    set_ch(1, -90);  tick();
    set_ch(1, -100); push_trig(2, 7'h10); tick();
    set_ch(1, -120); tick();
    set_ch(1, -60);  tick();
    set_ch(1, -100); tick();
    set_ch(1, -40);  tick();
    set_ch(1, -110); push_trig(2, 7'h10); tick();
    adc_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (trig_cnt_o !== exp_cnt) begin
      errors++;
      $display("FAIL ch2_falling_cnt got %0d want %0d", trig_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_ext();
    trig_en = 7'h01;
    ext_pol = 1'b0;
    ext_dly = 32'd3;
    ext_trig = 1'b1; push_trig(5, 7'h01); tick();
    ext_trig = 1'b0; tick();
    ext_trig = 1'b1; tick();
    repeat (8) tick();
    ext_trig = 1'b0; repeat (3) tick();
    ext_dly = 32'd0;
    ext_trig = 1'b1; push_trig(2, 7'h01); tick();
    repeat (5) tick();
    ext_pol = 1'b1;
    ext_trig = 1'b0; push_trig(2, 7'h01); tick();
    repeat (5) tick();
    ext_trig = 1'b1; repeat (4) tick();
    ext_pol = 1'b0;
    ext_trig = 1'b0; repeat (3) tick();
    checks++;
    if (sb_q.size() != 0 || trig_src_o !== 7'h01) begin
      errors++;
      $display("FAIL ext_done got queued=%0d src=%h want 0 01", sb_q.size(), trig_src_o);
    end
  endtask

  task automatic test_simultaneous();
    trig_en = 7'h7F;
    adc_valid = 1'b1;
    for (int k = 0; k < NCH; k++) set_ch(k, 0);
    tick();
    set_ch(2, 200); sw_trig = 1'b1; time_trig = 1'b1; push_trig(2, 7'h26); tick();
    sw_trig = 1'b0; time_trig = 1'b0; set_ch(2, 0); tick();
    repeat (3) tick();
    trig_en = 7'h02;
    set_ch(2, 200); sw_trig = 1'b1; time_trig = 1'b1; push_trig(2, 7'h02); tick();
    sw_trig = 1'b0; time_trig = 1'b0; set_ch(2, 0); tick();
    adc_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (trig_src_o !== 7'h02) begin
      errors++;
      $display("FAIL simul_src_hold got %h want 02", trig_src_o);
    end
  endtask

  task automatic test_abort();
    trig_en = 7'h01;
    ext_dly = 32'd100;
    ext_trig = 1'b1; tick();
    repeat (20) tick();
    arm = 1'b0; repeat (2) tick();
    arm = 1'b1; repeat (110) tick();
    ext_trig = 1'b0; tick();
    // leave ch1 armed so a missed detector reset would show up below
    adc_valid = 1'b1; set_ch(0, 0); tick(); adc_valid = 1'b0;
    ext_trig = 1'b1; tick();
    repeat (20) tick();
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    exp_cnt = 0;
    tick();
    checks++;
    if (trig_cnt_o !== 32'd0 || trig_src_o !== '0) begin
      errors++;
      $display("FAIL reset_abort got cnt=%0d src=%h want 0 00", trig_cnt_o, trig_src_o);
    end
    repeat (110) tick();
    ext_trig = 1'b0; tick();
    trig_en = 7'h08;
    adc_valid = 1'b1;
    set_ch(0, 800); tick();
    set_ch(0, 0);   tick();
    set_ch(0, 800); push_trig(2, 7'h08); tick();
    adc_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (trig_cnt_o !== 32'd1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_detector got cnt=%0d queued=%0d want 1 0", trig_cnt_o, sb_q.size());
    end
  endtask

  initial begin
    thres_val  = {16'h7FFF, 16'd100, 16'hFF9C, 16'h0300};
    thres_hyst = {16'd0, 16'd10, 16'd50, 16'h0100};
    ch_pol     = 4'b0010;
    test_reset();
    test_sw();
    test_ch1_ramp();
    test_ch_falling();
    test_ext();
    test_simultaneous();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_trig_unit.md
Name: adc_trig_unit

Overview:
Trigger unit of the FMC ADC 100Ms acquisition path. Sits between the per-channel gain/offset/saturation stage and the acquisition FSM. Detects trigger conditions from four sources: channel threshold crossings with hysteresis, the external trigger input with programmable delay, software trigger and time trigger. Produces one qualified trigger pulse, a latched source vector and a trigger counter for the acquisition FSM and the CSR block.

Parameters:
g_NB_CHAN, 4, number of ADC channels with threshold detectors
g_DATA_W, 16, signed sample width per channel
g_DLY_W, 32, external trigger delay counter width

Ports:
clk_i  in  1  sampling/system clock; all logic in this single domain
rst_i  in  1  synchronous reset, active-high
adc_data_i  in  g_NB_CHAN*g_DATA_W  signed corrected samples, ch1 in LSBs
adc_valid_i  in  1  qualifies adc_data_i
ch_thres_val_i  in  g_NB_CHAN*g_DATA_W  signed threshold per channel
ch_thres_hyst_i  in  g_NB_CHAN*g_DATA_W  unsigned hysteresis per channel
ch_pol_i  in  g_NB_CHAN  0 = rising crossing, 1 = falling crossing
trig_en_i  in  3+g_NB_CHAN  source enable mask: bit0 ext, bit1 sw, bit2 time, bit3+k ch(k+1)
ext_trig_i  in  1  external trigger level, already synchronised to clk_i
ext_pol_i  in  1  0 = rising edge, 1 = falling edge
ext_dly_i  in  g_DLY_W  external trigger delay in clk_i cycles
sw_trig_i  in  1  software trigger, single-cycle pulse
time_trig_i  in  1  time-tag trigger, single-cycle pulse
arm_i  in  1  high while the acquisition FSM accepts triggers
trig_o  out  1  qualified trigger, single-cycle pulse
trig_src_o  out  3+g_NB_CHAN  sources that caused the last trig_o
trig_cnt_o  out  32  number of trig_o pulses since reset

Behaviour:
- Reset: trig_o=0, trig_src_o=0, trig_cnt_o=0, delay counter idle, every detector in WAIT_FIRST, ext edge register loaded with ext_trig_i.
- Channel detector states: WAIT_FIRST, ARMED, DISARMED. Each detector updates only on adc_valid_i.
- Arithmetic: all compares in g_DATA_W+2 signed. re-arm level = thres-hyst for rising, thres+hyst for falling; no wrap.
- WAIT_FIRST (rising): first sample < thres -> ARMED, otherwise DISARMED. Falling mirrors this: first sample > thres -> ARMED.
- ARMED (rising): sample >= thres -> ch hit for one cycle, then DISARMED. Falling: sample <= thres.
- DISARMED (rising): sample < thres-hyst -> ARMED. Falling: sample > thres+hyst.
- hyst=0 degenerates to a plain crossing detector.
- External edge: edge = ext_trig_i XOR ext_q, qualified by ext_pol_i. ext_q is registered every cycle.
- ext_dly_i=0: ext hit on the cycle after the edge.
- ext_dly_i=D>0: counter loaded with D on the cycle after the edge, then decrements; ext hit when the count reaches 0. Total latency to trig_o is D+2.
- Edges while the counter runs are ignored.
- sw_trig_i and time_trig_i are registered into the hit vector directly.
- Pipeline stage 1: hit vector registered.
- Pipeline stage 2: trig_o = arm_i AND OR(hit & trig_en_i), registered. Latency is 2 cycles for sw, time, ext (D=0) and channel sources, measured from the input cycle.
- Simultaneous hits: one trig_o; trig_src_o holds every enabled hit bit of that cycle.
- trig_src_o updates only when trig_o fires and holds otherwise.
- trig_cnt_o increments on each trig_o and wraps 0xFFFFFFFF -> 0.
- arm_i low: hits are discarded and the delay counter is cleared. Detectors keep tracking hysteresis.
- Disabled sources: detectors keep running; their hits are masked.
- Reset mid-delay: counter cleared, no trig_o.

Decomposition:
- Package adc_trig_pkg: source bit indices (c_SRC_EXT=0, c_SRC_SW=1, c_SRC_TIME=2, c_SRC_CH1..4=3..6), detector state enum, g_DATA_W default.
- Sub-module adc_trig_thres_det: one threshold/hysteresis detector per channel, instantiated g_NB_CHAN times via generate.

Test Plan:
- SW trigger: arm_i=1, trig_en=0x02, sw_trig_i pulse at cycle N -> trig_o at N+2, trig_src_o=0x02, trig_cnt_o=1. Same with arm_i=0 -> no trig_o.
- Ch1 threshold: thres=0x300, hyst=0x100, rising, ch1 ramp from 0 in steps of +8. -> one trig_o 2 cycles after sample 768, trig_src_o=0x08.
- Ch1 re-arm: continue that ramp down to 504, then back up -> second trig_o at 768. Oscillation between 760 and 776 -> exactly one trig_o.
- Ext delay: trig_en=0x01, ext_dly=3, rising edge at N -> trig_o at N+5. 10 ns glitch pulses during the count -> no extra trig_o. ext_dly=0 -> trig_o at N+2.
- Simultaneous: sw, time and ch3 hits in the same cycle, trig_en=0x7F -> single trig_o, trig_src_o=0x26. With trig_en=0x02 -> trig_src_o=0x02.
- Reset/arm abort: arm_i dropped, or rst_i asserted, during a 100-cycle ext delay -> no trig_o. After reset, trig_cnt_o=0 and detectors are in WAIT_FIRST.
